// File: rtl/button_conditioner.sv
// button_conditioner: multi-channel push-button front end.
// Each channel has a synchroniser chain, a stable-count debouncer and
// registered rise/fall pulse generation. o_event selects between the
// pulses according to EDGE_MODE (0 rise, 1 fall, anything else both).
// Optional long-press detection is built when BTN_LONG_PRESS_EN is defined;
// otherwise o_long is tied low and no long counters exist.
module button_conditioner #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 50000,
    parameter int EDGE_MODE   = 0,
    parameter int LONG_CYCLES = 50000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] i_button,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_rise,
    output logic [N_CH-1:0] o_fall,
    output logic [N_CH-1:0] o_event,
    output logic [N_CH-1:0] o_long
);

    localparam int              DB_W    = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    // Reject parameter combinations the datapath cannot represent.
    if (N_CH < 1 || SYNC_STAGES < 2 || DB_CYCLES < 1 || LONG_CYCLES < 1) begin : g_param_check
        $error("button_conditioner: illegal parameter value");
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync;
        logic [DB_W-1:0]        db_cnt;
        logic                   level_q;
        logic                   rise_q;
        logic                   fall_q;
        logic                   fall_now;

        assign sync = sync_q[SYNC_STAGES-1];

        // True in the cycle whose clock edge will drop the debounced level.
        assign fall_now = level_q && !sync && (db_cnt == DB_LAST);

        // Shift the raw asynchronous input through the synchroniser chain.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], i_button[ch]};
            end
        end

        // Accept a new level only after DB_CYCLES consecutive mismatching cycles.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                db_cnt  <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (sync == level_q) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    db_cnt  <= '0;
                    level_q <= sync;
                    rise_q  <= sync;
                    fall_q  <= ~sync;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end
        end

        assign o_level[ch] = level_q;
        assign o_rise[ch]  = rise_q;
        assign o_fall[ch]  = fall_q;

`ifdef BTN_LONG_PRESS_EN
        localparam int                LONG_W    = $clog2(LONG_CYCLES + 1);
        localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

        logic [LONG_W-1:0] long_cnt;
        logic              armed;
        logic              long_q;

        // Count held-high time; fire once per press, re-arm only on release.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                long_cnt <= '0;
                armed    <= 1'b1;
                long_q   <= 1'b0;
            end else begin
                long_q <= 1'b0;
                if (!level_q) begin
                    long_cnt <= '0;
                    armed    <= 1'b1;
                end else begin
                    if (long_cnt != LONG_LAST) begin
                        long_cnt <= long_cnt + LONG_W'(1);
                    end
                    if ((long_cnt == LONG_LAST) && armed) begin
                        armed  <= 1'b0;
                        // A release landing on the threshold cycle wins.
                        long_q <= ~fall_now;
                    end
                end
            end
        end

        assign o_long[ch] = long_q;
`else
        assign o_long[ch] = 1'b0;
`endif
    end

    // Route the selected edge pulses to o_event; unknown modes report both.
    always_comb begin
        o_event = o_rise | o_fall;
        if (EDGE_MODE == 0) begin
            o_event = o_rise;
        end else if (EDGE_MODE == 1) begin
            o_event = o_fall;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed testbench for button_conditioner: two instances share clock,
// reset and buttons, one with EDGE_MODE=0 and one with EDGE_MODE=2.
// Long-press expectations follow BTN_LONG_PRESS_EN.
module tb_button_conditioner;

    logic       clk;
    logic       reset;
    logic [1:0] i_button;

    logic [1:0] lev0, rise0, fall0, evt0, long0;
    logic [1:0] lev2, rise2, fall2, evt2, long2;

    int vectors;
    int miscompares;

    button_conditioner #(
        .N_CH(2), .SYNC_STAGES(2), .DB_CYCLES(4), .EDGE_MODE(0), .LONG_CYCLES(10)
    ) dut0 (
        .clk(clk), .reset(reset), .i_button(i_button),
        .o_level(lev0), .o_rise(rise0), .o_fall(fall0), .o_event(evt0), .o_long(long0)
    );

    button_conditioner #(
        .N_CH(2), .SYNC_STAGES(2), .DB_CYCLES(4), .EDGE_MODE(2), .LONG_CYCLES(10)
    ) dut2 (
        .clk(clk), .reset(reset), .i_button(i_button),
        .o_level(lev2), .o_rise(rise2), .o_fall(fall2), .o_event(evt2), .o_long(long2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic settle(input logic [1:0] b);
        i_button = b;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [1:0] exp_lev, exp_rise;
        i_button = 2'b11;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({lev0, rise0, fall0, evt0, long0} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_hold_dut0 got %b want 0", {lev0, rise0, fall0, evt0, long0});
        end
        vectors++;
        if ({lev2, rise2, fall2, evt2, long2} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_hold_dut2 got %b want 0", {lev2, rise2, fall2, evt2, long2});
        end
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_lev  = (k >= 6) ? 2'b11 : 2'b00;
            exp_rise = (k == 6) ? 2'b11 : 2'b00;
            vectors++;
            if (lev0 !== exp_lev || rise0 !== exp_rise || evt0 !== exp_rise || fall0 !== 2'b00) begin
                miscompares++;
                $display("FAIL reset_release_dut0 k=%0d lev=%b rise=%b evt=%b fall=%b want lev=%b rise=%b",
                         k, lev0, rise0, evt0, fall0, exp_lev, exp_rise);
            end
            vectors++;
            if (lev2 !== exp_lev || rise2 !== exp_rise || evt2 !== exp_rise) begin
                miscompares++;
                $display("FAIL reset_release_dut2 k=%0d lev=%b rise=%b evt=%b want lev=%b rise=%b",
                         k, lev2, rise2, evt2, exp_lev, exp_rise);
            end
        end
        settle(2'b00);
    endtask

    task automatic test_clean_press();
        logic exp_lev, exp_rise, exp_fall;
        i_button = 2'b01;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp_lev  = (k >= 6);
            exp_rise = (k == 6);
            vectors++;
            if (lev0 !== {1'b0, exp_lev} || rise0 !== {1'b0, exp_rise} ||
                evt0 !== {1'b0, exp_rise} || fall0 !== 2'b00) begin
                miscompares++;
                $display("FAIL clean_press k=%0d lev=%b rise=%b evt=%b fall=%b want lev=0%b rise=0%b",
                         k, lev0, rise0, evt0, fall0, exp_lev, exp_rise);
            end
        end
        i_button = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_lev  = (k < 6);
            exp_fall = (k == 6);
            vectors++;
            if (lev0 !== {1'b0, exp_lev} || fall0 !== {1'b0, exp_fall} ||
                evt0 !== 2'b00 || rise0 !== 2'b00) begin
                miscompares++;
                $display("FAIL clean_release k=%0d lev=%b fall=%b evt=%b rise=%b want lev=0%b fall=0%b evt=00",
                         k, lev0, fall0, evt0, rise0, exp_lev, exp_fall);
            end
        end
        settle(2'b00);
    endtask

    task automatic test_glitch();
        logic exp_lev, exp_rise, exp_fall;
        // 3-cycle pulse must be rejected
        i_button = 2'b10;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 3) i_button = 2'b00;
            vectors++;
            if (lev0[1] !== 1'b0 || rise0[1] !== 1'b0 || fall0[1] !== 1'b0 || evt0[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL glitch3 k=%0d lev=%b rise=%b fall=%b evt=%b want all 0",
                         k, lev0[1], rise0[1], fall0[1], evt0[1]);
            end
        end
        // 4-cycle pulse is just long enough
        i_button = 2'b10;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 4) i_button = 2'b00;
            exp_lev  = (k >= 6) && (k < 10);
            exp_rise = (k == 6);
            exp_fall = (k == 10);
            vectors++;
            if (lev0[1] !== exp_lev || rise0[1] !== exp_rise || fall0[1] !== exp_fall ||
                evt0[1] !== exp_rise || lev0[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL glitch4 k=%0d lev=%b rise=%b fall=%b evt=%b want lev=%b rise=%b fall=%b",
                         k, lev0, rise0[1], fall0[1], evt0[1], exp_lev, exp_rise, exp_fall);
            end
        end
        settle(2'b00);
    endtask

    task automatic test_edge_both();
        logic exp_p;
        i_button = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_p = (k == 6);
            vectors++;
            if (evt2[0] !== exp_p || rise2[0] !== exp_p || fall2[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL both_press k=%0d evt=%b rise=%b fall=%b want evt=%b rise=%b",
                         k, evt2[0], rise2[0], fall2[0], exp_p, exp_p);
            end
        end
        i_button = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_p = (k == 6);
            vectors++;
            if (evt2[0] !== exp_p || fall2[0] !== exp_p || rise2[0] !== 1'b0 || evt0[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL both_release k=%0d evt=%b fall=%b rise=%b mode0_evt=%b want evt=%b fall=%b",
                         k, evt2[0], fall2[0], rise2[0], evt0[0], exp_p, exp_p);
            end
        end
        settle(2'b00);
    endtask

    task automatic test_long_press();
        logic exp_long;
        for (int rep = 0; rep < 2; rep++) begin
            i_button = 2'b01;
            for (int k = 1; k <= 30; k++) begin
                @(negedge clk);
`ifdef BTN_LONG_PRESS_EN
                exp_long = (k == 16);
`else
                exp_long = 1'b0;
`endif
                vectors++;
                if (long0 !== {1'b0, exp_long} || long2 !== {1'b0, exp_long}) begin
                    miscompares++;
                    $display("FAIL long_press rep=%0d k=%0d long0=%b long2=%b want 0%b",
                             rep, k, long0, long2, exp_long);
                end
            end
            i_button = 2'b00;
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk);
                vectors++;
                if (long0 !== 2'b00) begin
                    miscompares++;
                    $display("FAIL long_release rep=%0d k=%0d long0=%b want 00", rep, k, long0);
                end
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic exp_rise;
        settle(2'b10);
        i_button = 2'b11;
        repeat (4) @(negedge clk);
        vectors++;
        if (lev0 !== 2'b10) begin
            miscompares++;
            $display("FAIL mid_pre lev=%b want 10", lev0);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({lev0, rise0, fall0, evt0, long0, lev2, rise2, fall2, evt2, long2} !== 20'b0) begin
            miscompares++;
            $display("FAIL mid_async_clear dut0=%b dut2=%b want 0",
                     {lev0, rise0, fall0, evt0, long0}, {lev2, rise2, fall2, evt2, long2});
        end
        repeat (2) @(negedge clk);
        vectors++;
        if ({lev0, rise0, fall0, evt0, long0} !== 10'b0) begin
            miscompares++;
            $display("FAIL mid_in_reset dut0=%b want 0", {lev0, rise0, fall0, evt0, long0});
        end
        // Release reset with ch0 still held: it must look like a fresh press.
        i_button = 2'b01;
        reset    = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp_rise = (k == 6);
            vectors++;
            if (lev0 !== {1'b0, (k >= 6)} || rise0 !== {1'b0, exp_rise} ||
                fall0 !== 2'b00 || long0 !== 2'b00) begin
                miscompares++;
                $display("FAIL mid_fresh k=%0d lev=%b rise=%b fall=%b long=%b want rise=0%b",
                         k, lev0, rise0, fall0, long0, exp_rise);
            end
        end
        settle(2'b00);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        i_button    = 2'b11;
        test_reset();
        test_clean_press();
        test_glitch();
        test_edge_both();
        test_long_press();
        test_reset_mid_debounce();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised multi-channel push-button front end: per channel, a synchroniser, a stable-count debouncer and an edge/pulse generator with selectable edge mode, plus optional long-press detection. It sits between raw board buttons and the UART control logic, which consumes single-cycle event pulses and clean levels. It supersedes the single-channel rising-edge detector, which has no synchronisation depth, debounce, fall detection or multi-channel support.

## Interface
- N_CH, 4, number of independent button channels (>=1)
- SYNC_STAGES, 2, synchroniser flops per channel (>=2)
- DB_CYCLES, 50000, consecutive cycles a new synced value must persist before acceptance (>=1)
- EDGE_MODE, 0, o_event source: 0 rising, 1 falling, 2 both
- LONG_CYCLES, 50000000, held-high cycles for a long-press pulse (>=1; used only with BTN_LONG_PRESS_EN)

- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- i_button  input  N_CH  raw asynchronous button inputs, active high
- o_level  output  N_CH  debounced button level
- o_rise  output  N_CH  one-cycle pulse on debounced 0->1
- o_fall  output  N_CH  one-cycle pulse on debounced 1->0
- o_event  output  N_CH  one-cycle pulse per EDGE_MODE
- o_long  output  N_CH  one-cycle long-press pulse (tied 0 without BTN_LONG_PRESS_EN)

## Operation
- One clock, one reset. Reset is asynchronous and active-high. All flops clear on reset assertion: sync chains 0, debounce counters 0, o_level 0, all pulse outputs 0, long counters 0, long-armed flags 1.
- Channels are fully independent; no shared state.
- Synchroniser: SYNC_STAGES-deep shift chain; last stage is `sync`.
- Debouncer: counter width clog2(DB_CYCLES+1).
  - sync == o_level: counter cleared.
  - sync != o_level and counter < DB_CYCLES-1: counter increments.
  - sync != o_level and counter == DB_CYCLES-1: o_level <= sync, counter cleared.
  - Any mismatch interrupted by one matching cycle restarts from 0 (glitch rejection).
  - DB_CYCLES=1: o_level follows sync with one cycle of delay.
- Edge outputs are registered and assert in the same cycle o_level changes: o_rise when o_level goes 0->1, o_fall when 1->0, each exactly one cycle.
- o_event = o_rise (mode 0), o_fall (mode 1), o_rise|o_fall (mode 2). Other EDGE_MODE values are illegal; the implementation treats them as 2.
- Long press: see Configuration.
- Reset mid-operation: counters and pulses abort immediately; no pulse is emitted for a press in progress; after release, a button still held appears as a fresh press, with full debounce from 0.

## Timing
- Latency, stable raw change to o_level/o_rise/o_fall: SYNC_STAGES + DB_CYCLES rising edges.
- Raw pulses shorter than DB_CYCLES cycles after synchronisation never reach o_level.
- Minimum spacing between successive o_event pulses on one channel: DB_CYCLES cycles.
- o_rise and o_fall are never high in the same cycle on one channel.
- o_long rises LONG_CYCLES cycles after o_rise, in the cycle the long counter reaches LONG_CYCLES-1 while o_level=1.

## Configuration
- Macro BTN_LONG_PRESS_EN.
- Defined: per-channel counter, width clog2(LONG_CYCLES+1), counts while o_level=1 and saturates at LONG_CYCLES-1; clears and re-arms when o_level=0. o_long pulses one cycle when the count reaches LONG_CYCLES-1 and the channel is armed, then disarms. One pulse per press, no auto-repeat. Falling edge in the same cycle as the threshold suppresses the pulse.
- Undefined: no long counters are instantiated; o_long is constant 0.

## Test plan
Use N_CH=2, SYNC_STAGES=2, DB_CYCLES=4, LONG_CYCLES=10 unless stated otherwise.
- Reset: assert reset with i_button=2'b11 -> all outputs 0 while in reset; after release, o_level[1:0]=2'b11 and one o_rise pulse per channel 6 cycles after release.
- Clean press, ch0, EDGE_MODE=0: i_button[0] 0->1, held -> o_level[0]=1 and o_rise[0]=o_event[0]=1 for exactly 1 cycle, 6 cycles after the change; ch1 silent.
- Glitch rejection: 3-cycle high pulse on i_button[1] -> o_level[1] stays 0, no pulses; a 4-cycle pulse -> one o_rise[1] and, 4 cycles later, one o_fall[1].
- EDGE_MODE=2, press then release ch0 -> o_event[0] pulses twice, coincident with o_rise[0] then o_fall[0].
- With BTN_LONG_PRESS_EN, hold ch0 for 20 cycles past o_rise -> exactly one o_long[0] pulse, 10 cycles after o_rise; release, re-press -> second pulse. Without the macro -> o_long stays 0.
- Async reset mid-debounce: assert reset 2 cycles into a mismatch -> outputs clear within the same cycle; no pulse appears.
